// File: rtl/alias_reduction_pkg.sv
// Shared definitions for the alias-reduction engine: FSM state encoding,
// butterfly geometry, coefficient format and sample-RAM address helpers.
package alias_reduction_pkg;

  localparam int BUTTERFLIES         = 8;
  localparam int SAMPLES_PER_SUBBAND = 18;
  localparam int COEF_FRAC_BITS      = 17;
  localparam int ADDR_W              = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD_U,
    RD_D,
    MULT,
    WR_U,
    WR_D,
    DONE
  } state_e;

  // Upper butterfly operand: last sample of subband sb-1, walking downwards.
  function automatic logic [ADDR_W-1:0] up_addr(input logic [ADDR_W-1:0] sb,
                                                input logic [2:0]        i);
    return ADDR_W'(sb * ADDR_W'(SAMPLES_PER_SUBBAND)) - ADDR_W'(1)
           - {{(ADDR_W-3){1'b0}}, i};
  endfunction

  // Lower butterfly operand: first sample of subband sb, walking upwards.
  function automatic logic [ADDR_W-1:0] dn_addr(input logic [ADDR_W-1:0] sb,
                                                input logic [2:0]        i);
    return ADDR_W'(sb * ADDR_W'(SAMPLES_PER_SUBBAND))
           + {{(ADDR_W-3){1'b0}}, i};
  endfunction

endpackage

// File: rtl/alias_reduction_engine_dp.sv
// Butterfly datapath: holds bu/cs/ca operands, forms the two cross products
// at full precision, rounds half-up at bit 16, shifts by 17 and saturates.
// u' is produced combinationally while bd sits on the RAM read port; d' is
// registered at the same time so it can be written one cycle after u'.
module alias_butterfly_dp #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_u_i,
  input  logic                  load_d_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [DATA_WIDTH-1:0] cs_i,
  input  logic [DATA_WIDTH-1:0] ca_i,
  output logic [DATA_WIDTH-1:0] u_res_o,
  output logic [DATA_WIDTH-1:0] d_res_o
);
  import alias_reduction_pkg::*;

  // One spare bit above the product width so the sum/difference never wraps.
  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam logic signed [PW-1:0] ROUND_BIAS = PW'(1) << (COEF_FRAC_BITS - 1);
  localparam logic signed [PW-1:0] MAXV       = (PW'(1) << (DATA_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV       = ~MAXV;

  logic [DATA_WIDTH-1:0] bu_q, cs_q, ca_q, d_q;
  logic signed [PW-1:0]  bu_x, bd_x, cs_x, ca_x;
  logic signed [PW-1:0]  u_sum, d_sum;

  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] r;
    r = (v + ROUND_BIAS) >>> COEF_FRAC_BITS;
    if (r > MAXV) return MAXV[DATA_WIDTH-1:0];
    if (r < MINV) return MINV[DATA_WIDTH-1:0];
    return r[DATA_WIDTH-1:0];
  endfunction

  assign bu_x = {{(PW-DATA_WIDTH){bu_q[DATA_WIDTH-1]}}, bu_q};
  assign bd_x = {{(PW-DATA_WIDTH){rdata_i[DATA_WIDTH-1]}}, rdata_i};
  assign cs_x = {{(PW-DATA_WIDTH){cs_q[DATA_WIDTH-1]}}, cs_q};
  assign ca_x = {{(PW-DATA_WIDTH){ca_q[DATA_WIDTH-1]}}, ca_q};

  assign u_sum = bu_x * cs_x - bd_x * ca_x;
  assign d_sum = bd_x * cs_x + bu_x * ca_x;

  assign u_res_o = round_sat(u_sum);
  assign d_res_o = d_q;

  // Capture the upper sample with its coefficients, later the rounded d'.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bu_q <= '0;
      cs_q <= '0;
      ca_q <= '0;
      d_q  <= '0;
    end else begin
      if (load_u_i) begin
        bu_q <= rdata_i;
        cs_q <= cs_i;
        ca_q <= ca_i;
      end
      if (load_d_i) begin
        d_q <= round_sat(d_sum);
      end
    end
  end

endmodule

// File: rtl/alias_reduction_engine.sv
// Alias-reduction engine top: granule FSM, boundary/butterfly counters and
// sample-RAM / coefficient-ROM address generation. Five cycles per butterfly.
// Optional macro ALIAS_REDUCTION_MIXED_EN: short+mixed granules process only
// boundary 1; without it mixed_block is ignored and short granules are skipped.
module alias_reduction_engine #(
  parameter int NUM_SUBBANDS = 32,
  parameter int DATA_WIDTH   = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  short_block,
  input  logic                  mixed_block,
  output logic                  busy,
  output logic                  done,
  output logic                  coef_enable,
  output logic [2:0]            coef_index,
  input  logic [DATA_WIDTH-1:0] cs_data,
  input  logic [DATA_WIDTH-1:0] ca_data,
  output logic [9:0]            ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wdata
);
  import alias_reduction_pkg::*;

  localparam int              SB_W    = $clog2(NUM_SUBBANDS);
  localparam logic [SB_W-1:0] LAST_SB = SB_W'(NUM_SUBBANDS - 1);
  localparam logic [2:0]      LAST_I  = 3'(BUTTERFLIES - 1);

  state_e                state_q, state_d;
  logic [SB_W-1:0]       sb_q, sb_d;
  logic [2:0]            i_q, i_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [2:0]            coef_index_q, coef_index_d;
  logic [SB_W-1:0]       last_sb;
  logic                  take_granule;
  logic                  load_u, load_d;
  logic [DATA_WIDTH-1:0] u_res, d_res;

`ifdef ALIAS_REDUCTION_MIXED_EN
  logic mixed_q, mixed_d;
  assign last_sb = mixed_q ? SB_W'(1) : LAST_SB;
`else
  logic unused_mixed;
  assign unused_mixed = mixed_block;
  assign last_sb      = LAST_SB;
`endif

  // Strobes and status decode straight from the state register.
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign ram_rd_en   = (state_q == RD_U) || (state_q == RD_D);
  assign coef_enable = (state_q == RD_U);
  assign ram_wr_en   = (state_q == WR_U) || (state_q == WR_D);
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign coef_index  = coef_index_q;

  alias_butterfly_dp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .load_u_i(load_u),
    .load_d_i(load_d),
    .rdata_i (ram_rdata),
    .cs_i    (cs_data),
    .ca_i    (ca_data),
    .u_res_o (u_res),
    .d_res_o (d_res)
  );

  // Next state, counters and the held address/data/index registers.
  always_comb begin
    state_d      = state_q;
    sb_d         = sb_q;
    i_d          = i_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    coef_index_d = coef_index_q;
    take_granule = 1'b0;
    load_u       = 1'b0;
    load_d       = 1'b0;
`ifdef ALIAS_REDUCTION_MIXED_EN
    mixed_d      = mixed_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ALIAS_REDUCTION_MIXED_EN
          take_granule = !short_block || mixed_block;
          mixed_d      = short_block && mixed_block;
`else
          take_granule = !short_block;
`endif
          if (take_granule) begin
            state_d      = RD_U;
            sb_d         = SB_W'(1);
            i_d          = 3'd0;
            ram_addr_d   = up_addr(ADDR_W'(1), 3'd0);
            coef_index_d = 3'd0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_U: begin
        state_d    = RD_D;
        ram_addr_d = dn_addr(ADDR_W'(sb_q), i_q);
      end
      RD_D: begin
        state_d = MULT;
        load_u  = 1'b1;
      end
      MULT: begin
        state_d     = WR_U;
        load_d      = 1'b1;
        ram_addr_d  = up_addr(ADDR_W'(sb_q), i_q);
        ram_wdata_d = u_res;
      end
      WR_U: begin
        state_d     = WR_D;
        ram_addr_d  = dn_addr(ADDR_W'(sb_q), i_q);
        ram_wdata_d = d_res;
      end
      WR_D: begin
        if ((i_q == LAST_I) && (sb_q == last_sb)) begin
          state_d = DONE;
        end else begin
          if (i_q == LAST_I) begin
            sb_d = sb_q + SB_W'(1);
            i_d  = 3'd0;
          end else begin
            i_d = i_q + 3'd1;
          end
          state_d      = RD_U;
          ram_addr_d   = up_addr(ADDR_W'(sb_d), i_d);
          coef_index_d = i_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        sb_d    = SB_W'(1);
        i_d     = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and held-output registers; reset aborts any granule in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sb_q         <= SB_W'(1);
      i_q          <= 3'd0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      coef_index_q <= 3'd0;
`ifdef ALIAS_REDUCTION_MIXED_EN
      mixed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sb_q         <= sb_d;
      i_q          <= i_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      coef_index_q <= coef_index_d;
`ifdef ALIAS_REDUCTION_MIXED_EN
      mixed_q      <= mixed_d;
`endif
    end
  end

endmodule
